// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-channel TDM demultiplexer locking to a frame marker
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_vld,
    input  logic             frm,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_vld,
    output logic             frame_done,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t     state_q, state_n;
    logic [1:0] cnt_q, cnt_n;

    logic       wr_en;
    logic [1:0] slot;
    logic       done_n;
    logic       err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            HUNT: begin
                if (in_vld && frm) begin
                    state_n = LOCK;
                    cnt_n   = 2'd1;
                end
            end
            LOCK: begin
                if (in_vld) begin
                    cnt_n = frm ? 2'd1 : cnt_q + 2'd1;
                end
            end
            default: begin
                state_n = HUNT;
                cnt_n   = 2'd0;
            end
        endcase
    end

    // A marker always forces slot 0; in HUNT only marker beats are accepted.
    always_comb begin
        wr_en  = 1'b0;
        slot   = 2'd0;
        done_n = 1'b0;
        err_n  = 1'b0;
        case (state_q)
            HUNT: begin
                wr_en = in_vld && frm;
            end
            LOCK: begin
                wr_en  = in_vld;
                slot   = frm ? 2'd0 : cnt_q;
                done_n = in_vld && !frm && (cnt_q == 2'd3);
                err_n  = in_vld && frm && (cnt_q != 2'd0);
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out0       <= '0;
            out1       <= '0;
            out2       <= '0;
            out3       <= '0;
            out_vld    <= 4'd0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            out_vld    <= 4'd0;
            frame_done <= done_n;
            sync_err   <= err_n;
            if (wr_en) begin
                out_vld[slot] <= 1'b1;
                case (slot)
                    2'd0:    out0 <= in;
                    2'd1:    out1 <= in;
                    2'd2:    out2 <= in;
                    default: out3 <= in;
                endcase
            end
        end
    end

    assign locked = (state_q == LOCK);

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of a serial TDM link whose transmit end is a 2:1/4:1 select mux stepping through channels. It takes one `WIDTH`-bit sample per valid beat and locks to a frame marker. Each sample is steered into one of four held output registers, with per-channel update strobes. It sits after the link/mux stage and feeds per-channel consumers that need a stable value between updates.

## Interface
- `WIDTH`, 8, sample width in bits (1..32)
- `clk` input 1, single system clock, all logic on rising edge
- `rst` input 1, synchronous, active-high reset
- `in` input WIDTH, TDM sample data
- `in_vld` input 1, `in` carries a sample this cycle (one beat)
- `frm` input 1, frame marker; when high with `in_vld`, the beat is channel 0
- `out0`..`out3` output WIDTH each, last sample received for channel 0..3, held between updates
- `out_vld` output 4, bit k pulses one cycle when `out<k>` was just updated
- `frame_done` output 1, one-cycle pulse when channel 3 of a frame is written
- `locked` output 1, high in state LOCK
- `sync_err` output 1, one-cycle pulse on an early frame marker

## Operation
- Reset (synchronous, `rst`=1 at a rising edge):
  - State goes to HUNT and the slot counter `cnt` (2 bits) goes to 0.
  - `out0`..`out3`, `out_vld`, `frame_done`, `locked` and `sync_err` all go to 0.
  - Reset takes priority over any beat in the same cycle, including mid-frame; the partial frame is discarded.
- A beat is a cycle with `in_vld`=1. `frm` without `in_vld` is ignored in every state.
- HUNT state:
  - Beats with `frm`=0 are discarded; no output changes.
  - A beat with `frm`=1 moves the state to LOCK. That beat is written to `out0` as slot 0, and `cnt` becomes 1.
- LOCK state, on each beat:
  - The effective slot is `s = frm ? 0 : cnt`.
  - `out<s>` is written with `in` and `out_vld[s]` pulses; the other outputs hold.
  - `cnt` becomes `s+1` mod 4, wrapping from 3 to 0.
  - If `s`==3, `frame_done` pulses.
  - If `frm`=1 and `cnt`!=0 (marker arrives mid-frame), `sync_err` pulses and the frame is realigned: the beat is written as slot 0 and `cnt` becomes 1. Channels not yet written in the aborted frame keep their old values. `frame_done` does not pulse for the aborted frame.
  - If `frm`=1 and `cnt`==0, this is a normal frame boundary with no error.
  - If `frm`=0 and `cnt`==0, the frame continues free-running with no marker, which is legal. The state stays LOCK; the marker is not required on every frame.
- No path from LOCK back to HUNT except `rst`.
- Gaps (`in_vld`=0) between beats are allowed at any length and do not advance `cnt`.

## Timing
- Latency is one cycle: a beat sampled at edge N appears on `out<s>` with `out_vld[s]`=1 after edge N.
  - `frame_done` and `sync_err` are asserted in that same cycle.
- All outputs are registered; there is no combinational path from input to output.
- `out_vld`, `frame_done` and `sync_err` are high for exactly one cycle per causing beat. With back-to-back beats, `out_vld` is one-hot every cycle.
- `locked` rises in the cycle after the HUNT-exiting beat, together with `out_vld[0]`.
- Throughput is one sample per cycle, with no backpressure.

## Test plan
- Reset/hunt:
  - Stimulus: assert `rst` for 2 cycles, then send beats 0x11, 0x22 with `frm`=0.
  - Required: all outputs stay 0 and `locked`=0.
- Lock and full frame:
  - Stimulus: back-to-back beats 0xA0 (`frm`=1), 0xA1, 0xA2, 0xA3.
  - Required: `out0..3`=A0,A1,A2,A3; `out_vld` sequence 0001,0010,0100,1000; `frame_done` on the 4th output cycle; `locked`=1 from the first output cycle.
- Wrap without marker and gaps:
  - Stimulus: after the lock-and-full-frame case, send beats 0xB0..0xB3 with `frm`=0 and 3 idle cycles between each.
  - Required: `out0..3`=B0..B3; one `out_vld` pulse per beat, each one cycle after its beat; `frame_done` once; no `sync_err`.
- Early marker:
  - Stimulus: in LOCK, send 0xC0 (`frm`), 0xC1, then 0xD0 with `frm`=1.
  - Required: `sync_err` pulses with `out_vld`=0001; `out0`=D0, `out1`=C1, `out2`/`out3` unchanged; the next beat goes to `out1`.
- `frm` without `in_vld`:
  - Stimulus: in LOCK with `cnt`=2, hold `frm`=1 and `in_vld`=0 for 2 cycles, then send beat 0xE2 with `frm`=0.
  - Required: `out2`=E2 and no `sync_err`.
- Reset mid-frame:
  - Stimulus: lock, send 2 beats, assert `rst` in the same cycle as a third beat 0xF2.
  - Required: all outputs 0, `locked`=0, `out2` not written; re-lock requires a new `frm` beat.
